// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_cell
// Brief    : One-bit full adder, the building block of the ripple-carry adder.
//            Sum is the three-input XOR; carry is the three-input majority.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Plain gate equations; X/Z on any input flows straight to the outputs.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Brief    : WIDTH-bit ripple-carry adder, {carry_out,sum} = a + b + carry_in,
//            with zero-latency combinational outputs and an optional one-cycle
//            registered copy (sum_q, carry_q, valid_q) using async reset.
// Revision : 1.0 - initial release
// ============================================================================
module adder #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             valid_q
);

  // Carry chain: w_c[0] is the carry into bit 0, w_c[WIDTH] leaves the MSB.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  assign w_c[0] = carry_in;

  // One cell per bit, each feeding its carry to the next more significant bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .s    (w_s[i]),
      .cout (w_c[i+1])
    );
  end

  assign sum       = w_s;
  assign carry_out = w_c[WIDTH];

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] r_sum_q;
    logic             r_carry_q;
    logic             r_valid_q;

    // Capture the combinational result each edge; reset clears it at once.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sum_q   <= '0;
        r_carry_q <= 1'b0;
        r_valid_q <= 1'b0;
      end else begin
        r_sum_q   <= w_s;
        r_carry_q <= w_c[WIDTH];
        r_valid_q <= 1'b1;
      end
    end

    assign sum_q   = r_sum_q;
    assign carry_q = r_carry_q;
    assign valid_q = r_valid_q;
  end else begin : g_noreg
    // No registered stage requested: outputs are tied off, no flops exist.
    assign sum_q   = '0;
    assign carry_q = 1'b0;
    assign valid_q = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder
// Brief    : Self-checking bench for adder. An 8-bit instance with the output
//            register and a 1-bit instance without it are driven together and
//            compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] a8 = '0, b8 = '0;
  logic       ci8 = 1'b0;
  logic [7:0] sum8, sum_q8;
  logic       co8, carry_q8, valid_q8;

  logic       a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
  logic       sum1, co1, sum_q1, carry_q1, valid_q1;

  int n_pass  = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  // Reference model of the registered stage of the 8-bit instance.
  logic [8:0] m_q     = '0;
  logic       m_valid = 1'b0;

  always #5 clk = ~clk;

  adder #(.WIDTH(8), .REG_OUT(1)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .carry_in(ci8),
    .sum(sum8), .carry_out(co8), .sum_q(sum_q8), .carry_q(carry_q8),
    .valid_q(valid_q8)
  );

  adder #(.WIDTH(1), .REG_OUT(0)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .carry_in(ci1),
    .sum(sum1), .carry_out(co1), .sum_q(sum_q1), .carry_q(carry_q1),
    .valid_q(valid_q1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the register holds the 9-bit arithmetic sum seen at the last edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     = '0;
      m_valid = 1'b0;
    end else begin
      m_q     = 9'(a8) + 9'(b8) + 9'(ci8);
      m_valid = 1'b1;
    end
  end

  // Compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      logic [8:0] e8;
      logic [1:0] e1;
      e8 = 9'(a8) + 9'(b8) + 9'(ci8);
      e1 = 2'(a1) + 2'(b1) + 2'(ci1);
      chk("comb8",   {23'd0, co8, sum8}, {23'd0, e8});
      chk("reg8",    {23'd0, carry_q8, sum_q8}, {23'd0, m_q});
      chk("valid8",  {31'd0, valid_q8}, {31'd0, m_valid});
      chk("comb1",   {30'd0, co1, sum1}, {30'd0, e1});
      chk("noreg1",  {29'd0, sum_q1, carry_q1, valid_q1}, 32'd0);
    end
  end

  logic [2:0] tt_in  [8];
  logic [1:0] tt_out [8];

  initial begin
    // Truth table (a,b,carry_in) -> (sum,carry_out), from hand calculation.
    tt_in[0] = 3'b000; tt_out[0] = 2'b00;
    tt_in[1] = 3'b100; tt_out[1] = 2'b10;
    tt_in[2] = 3'b110; tt_out[2] = 2'b01;
    tt_in[3] = 3'b010; tt_out[3] = 2'b10;
    tt_in[4] = 3'b011; tt_out[4] = 2'b01;
    tt_in[5] = 3'b001; tt_out[5] = 2'b10;
    tt_in[6] = 3'b101; tt_out[6] = 2'b01;
    tt_in[7] = 3'b111; tt_out[7] = 2'b11;

    // Reset state, also across a clock edge while rst is held.
    #2;
    chk("rst_sum_q",   {24'd0, sum_q8}, 32'd0);
    chk("rst_carry_q", {31'd0, carry_q8}, 32'd0);
    chk("rst_valid_q", {31'd0, valid_q8}, 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_q", {22'd0, valid_q8, carry_q8, sum_q8}, 32'd0);

    // WIDTH=1 truth table; outputs settle within one time step.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, ci1} = tt_in[i];
      #1;
      chk($sformatf("tt1_%03b", tt_in[i]), {30'd0, sum1, co1}, {30'd0, tt_out[i]});
    end

    // WIDTH=8 boundary cases; combinational outputs track inputs under reset.
    a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0; #1;
    chk("zero8", {23'd0, co8, sum8}, 32'h000);
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; #1;
    chk("ff_01_0", {23'd0, co8, sum8}, 32'h100);
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; #1;
    chk("ff_ff_1", {23'd0, co8, sum8}, 32'h1FF);

    // Release reset with 3+4 and check the first registered result.
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd4; ci8 = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_sum_q",   {24'd0, sum_q8}, 32'd7);
    chk("rel_valid_q", {31'd0, valid_q8}, 32'd1);
    chk("rel_carry_q", {31'd0, carry_q8}, 32'd0);

    // Async reset between edges clears the register immediately.
    #2; rst = 1'b1; #1;
    chk("async_sum_q",   {24'd0, sum_q8}, 32'd0);
    chk("async_valid_q", {31'd0, valid_q8}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Randomized vectors with occasional reset pulses, checked by the model.
    @(posedge clk); #1;
    check_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      ci8 = 1'($urandom);
      {a1, b1, ci1} = 3'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
